imem_fetch: RTL and testbench

Parametrised, clocked instruction memory with a valid/ready fetch port, a program-load write port and a response buffer. It replaces the combinational instruction ROM for the pipelined core. It sits between the PC/fetch stage and decode: fetch issues byte-address requests and decode consumes buffered instruction words. Program images are written through the load port after reset instead of being read from a file.

---
 rtl/imem_fetch.sv | 132 +++++++++++++
 tb/tb_imem_fetch.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch.sv
// Clocked instruction memory with a program-load port, a valid/ready fetch
// port and an in-order response FIFO sized to the outstanding-request limit.
module imem_fetch #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 10,
   parameter int PC_W      = 32,
   parameter int BUF_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_we,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   input  logic              boot_done,
   input  logic              flush,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [PC_W-1:0]   req_pc,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_instr,
   output logic [PC_W-1:0]   rsp_pc,
   output logic              rsp_err
);

   localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CNT_W = $clog2(BUF_DEPTH + 1);

   typedef enum logic {
      LOAD = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t state_q, state_d;

   logic [DATA_W-1:0] mem [2**ADDR_W];
   logic [DATA_W-1:0] rd_data;

   logic              inf_valid;
   logic              inf_err;
   logic [PC_W-1:0]   inf_pc;

   logic [DATA_W-1:0]    fifo_data [BUF_DEPTH];
   logic [PC_W-1:0]      fifo_pc   [BUF_DEPTH];
   logic [BUF_DEPTH-1:0] fifo_err;
   logic [PTR_W-1:0]     wr_ptr, rd_ptr;
   logic [CNT_W-1:0]     count;
   logic [CNT_W:0]       outstanding;

   logic [ADDR_W-1:0] word_idx;
   logic              req_err;
   logic              accept;
   logic              push;
   logic              pop;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign word_idx    = req_pc[ADDR_W+1:2];
   assign req_err     = (req_pc[1:0] != 2'b00) ||
                        ((req_pc >> (ADDR_W + 2)) != '0);
   assign outstanding = {1'b0, count} + (CNT_W + 1)'(inf_valid);
   assign rsp_valid   = (count != '0);
   assign pop         = rsp_valid && rsp_ready;
   assign accept      = req_valid && req_ready;
   // A flush kills the in-flight read before it reaches the FIFO.
   assign push        = inf_valid && !flush;

   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      unique case (state_q)
         LOAD: begin
            if (boot_done) state_d = RUN;
         end
         RUN: begin
            req_ready = !flush &&
                        ((outstanding < (CNT_W + 1)'(BUF_DEPTH)) || pop);
         end
         default: state_d = LOAD;
      endcase
   end

   // Read-before-write: a same-word read in the write cycle sees old data.
   always_ff @(posedge clk) begin
      if (load_we) mem[load_addr] <= load_data;
      if (accept && !req_err) rd_data <= mem[word_idx];
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr] <= inf_err ? '0 : rd_data;
         fifo_pc[wr_ptr]   <= inf_pc;
         fifo_err[wr_ptr]  <= inf_err;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= LOAD;
         inf_valid <= 1'b0;
         inf_err   <= 1'b0;
         inf_pc    <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
      end else begin
         state_q   <= state_d;
         inf_valid <= accept;
         if (accept) begin
            inf_err <= req_err;
            inf_pc  <= req_pc;
         end
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
         end
      end
   end

   assign rsp_instr = rsp_valid ? fifo_data[rd_ptr] : '0;
   assign rsp_pc    = rsp_valid ? fifo_pc[rd_ptr] : '0;
   assign rsp_err   = rsp_valid && fifo_err[rd_ptr];

endmodule

// File: tb/tb_imem_fetch.sv
// Randomised bench for imem_fetch against a queue-based transaction model.
// Inputs change on the falling edge; outputs are checked just after it.
module tb_imem_fetch;

   localparam int DW = 32;
   localparam int AW = 10;
   localparam int PW = 32;
   localparam int BD = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          load_we;
   logic [AW-1:0] load_addr;
   logic [DW-1:0] load_data;
   logic          boot_done;
   logic          flush;
   logic          req_valid;
   logic          req_ready;
   logic [PW-1:0] req_pc;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_instr;
   logic [PW-1:0] rsp_pc;
   logic          rsp_err;

   imem_fetch #(
      .DATA_W(DW), .ADDR_W(AW), .PC_W(PW), .BUF_DEPTH(BD)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
      .boot_done(boot_done), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_instr(rsp_instr), .rsp_pc(rsp_pc), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [PW-1:0] pc;
      logic          err;
      logic [DW-1:0] data;
      int            edge_n;
   } ent_t;

   ent_t          q[$];
   logic [DW-1:0] mem_m [1<<AW];
   bit            run;
   int            nedges = 0;

   logic          e_rdy, e_vld, e_err;
   logic [DW-1:0] e_instr;
   logic [PW-1:0] e_pc;

   task automatic idle();
      rst_n     = 1'b1;
      load_we   = 1'b0;
      load_addr = '0;
      load_data = '0;
      boot_done = 1'b0;
      flush     = 1'b0;
      req_valid = 1'b0;
      req_pc    = '0;
      rsp_ready = 1'b0;
   endtask

   // Expected outputs: a response is visible one edge after the edge at
   // which its read was captured; slots are every accepted, unpopped request.
   task automatic exp_calc();
      e_vld = 1'b0;
      e_instr = '0;
      e_pc = '0;
      e_err = 1'b0;
      if (q.size() > 0) begin
         if (nedges >= q[0].edge_n + 1) begin
            e_vld   = 1'b1;
            e_instr = q[0].data;
            e_pc    = q[0].pc;
            e_err   = q[0].err;
         end
      end
      e_rdy = run && !flush &&
              ((q.size() < BD) || (e_vld && rsp_ready));
   endtask

   task automatic tick();
      bit acc, pop;
      ent_t ent;
      acc = req_valid && e_rdy;
      pop = e_vld && rsp_ready;
      @(posedge clk);
      nedges++;
      if (!rst_n) begin
         run = 1'b0;
         q.delete();
      end else begin
         if (pop) void'(q.pop_front());
         if (flush) q.delete();
         if (acc) begin
            ent.pc     = req_pc;
            ent.err    = (req_pc[1:0] != 2'b00) || ((req_pc >> (AW + 2)) != 0);
            ent.data   = ent.err ? '0 : mem_m[req_pc[AW+1:2]];
            ent.edge_n = nedges;
            q.push_back(ent);
         end
         if (boot_done) run = 1'b1;
      end
      if (load_we) mem_m[load_addr] = load_data;
      @(negedge clk);
   endtask

   function automatic logic [PW-1:0] rand_pc();
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r == 0) return PW'(($urandom_range(0, 63) << 2) | $urandom_range(1, 3));
      if (r == 1) return PW'(32'h1000 | ($urandom & 32'hFFFF_FFFC));
      return PW'($urandom_range(0, 63) << 2);
   endfunction

   task automatic test_reset();
      idle();
      rst_n = 1'b0;
      repeat (2) begin
         exp_calc();
         tick();
      end
      #1;
      checks++;
      if (req_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset req_ready got=%0b exp=0", req_ready);
      end
      checks++;
      if (rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset rsp_valid got=%0b exp=0", rsp_valid);
      end
      checks++;
      if ({rsp_instr, rsp_pc, rsp_err} !== '0) begin
         failures++;
         $display("FAIL reset rsp_data got=%h/%h/%0b exp=0", rsp_instr, rsp_pc, rsp_err);
      end
      exp_calc();
      tick();
   endtask

   task automatic test_load();
      logic [DW-1:0] prog [4];
      prog = '{32'h2008_0001, 32'h2009_0002, 32'h0109_5020, 32'h0000_0000};
      for (int i = 0; i <= 64; i++) begin
         idle();
         req_valid = 1'b1;
         req_pc    = PW'(i * 4);
         if (i < 64) begin
            load_we   = 1'b1;
            load_addr = AW'(i);
            load_data = (i < 4) ? prog[i] : (i == 5) ? 32'h1111_1111 : $urandom;
         end else begin
            boot_done = 1'b1;
         end
         #1;
         exp_calc();
         checks++;
         if (req_ready !== e_rdy) begin
            failures++;
            $display("FAIL load_ready cyc=%0d got=%0b exp=%0b", i, req_ready, e_rdy);
         end
         tick();
      end
   endtask

   task automatic test_basic();
      for (int c = 0; c < 10; c++) begin
         idle();
         rsp_ready = 1'b1;
         req_valid = (c < 3);
         req_pc    = PW'(c * 4);
         #1;
         exp_calc();
         checks++;
         if (req_ready !== e_rdy) begin
            failures++;
            $display("FAIL basic req_ready got=%0b exp=%0b", req_ready, e_rdy);
         end
         checks++;
         if (rsp_valid !== e_vld) begin
            failures++;
            $display("FAIL basic rsp_valid got=%0b exp=%0b", rsp_valid, e_vld);
         end
         if (e_vld) begin
            checks++;
            if ({rsp_instr, rsp_pc, rsp_err} !== {e_instr, e_pc, e_err}) begin
               failures++;
               $display("FAIL basic rsp got=%h/%h/%0b exp=%h/%h/%0b",
                        rsp_instr, rsp_pc, rsp_err, e_instr, e_pc, e_err);
            end
         end
         tick();
      end
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL basic drain left=%0d exp=0", q.size());
      end
   endtask

   task automatic test_backpressure();
      int acc = 0;
      for (int c = 0; c < 20; c++) begin
         idle();
         rsp_ready = (c >= 6);
         req_valid = (c < 14);
         req_pc    = PW'($urandom_range(0, 63) << 2);
         #1;
         exp_calc();
         if (c < 6 && req_valid && req_ready) acc++;
         checks++;
         if (req_ready !== e_rdy) begin
            failures++;
            $display("FAIL bp req_ready cyc=%0d got=%0b exp=%0b", c, req_ready, e_rdy);
         end
         checks++;
         if (rsp_valid !== e_vld) begin
            failures++;
            $display("FAIL bp rsp_valid cyc=%0d got=%0b exp=%0b", c, rsp_valid, e_vld);
         end
         if (e_vld) begin
            checks++;
            if ({rsp_instr, rsp_pc, rsp_err} !== {e_instr, e_pc, e_err}) begin
               failures++;
               $display("FAIL bp rsp got=%h/%h/%0b exp=%h/%h/%0b",
                        rsp_instr, rsp_pc, rsp_err, e_instr, e_pc, e_err);
            end
         end
         tick();
      end
      checks++;
      if (acc != BD) begin
         failures++;
         $display("FAIL bp accepts got=%0d exp=%0d", acc, BD);
      end
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL bp drain left=%0d exp=0", q.size());
      end
   endtask

   task automatic test_errors();
      logic [PW-1:0] seq [3];
      seq = '{32'h6, 32'h4, 32'h1000};
      for (int c = 0; c < 9; c++) begin
         idle();
         rsp_ready = 1'b1;
         req_valid = (c < 3);
         req_pc    = (c < 3) ? seq[c] : '0;
         #1;
         exp_calc();
         checks++;
         if (req_ready !== e_rdy) begin
            failures++;
            $display("FAIL err req_ready got=%0b exp=%0b", req_ready, e_rdy);
         end
         checks++;
         if (rsp_valid !== e_vld) begin
            failures++;
            $display("FAIL err rsp_valid got=%0b exp=%0b", rsp_valid, e_vld);
         end
         if (e_vld) begin
            checks++;
            if ({rsp_instr, rsp_pc, rsp_err} !== {e_instr, e_pc, e_err}) begin
               failures++;
               $display("FAIL err rsp got=%h/%h/%0b exp=%h/%h/%0b",
                        rsp_instr, rsp_pc, rsp_err, e_instr, e_pc, e_err);
            end
         end
         tick();
      end
   endtask

   task automatic test_flush();
      for (int c = 0; c < 10; c++) begin
         idle();
         rsp_ready = (c >= 3);
         unique case (c)
            0: begin req_valid = 1'b1; req_pc = 32'h8; end
            1: begin req_valid = 1'b1; req_pc = 32'hC; end
            2: begin flush = 1'b1; req_valid = 1'b1; req_pc = 32'h4; end
            3: begin req_valid = 1'b1; req_pc = 32'h0; end
            default: ;
         endcase
         #1;
         exp_calc();
         checks++;
         if (req_ready !== e_rdy) begin
            failures++;
            $display("FAIL flush req_ready cyc=%0d got=%0b exp=%0b", c, req_ready, e_rdy);
         end
         checks++;
         if (rsp_valid !== e_vld) begin
            failures++;
            $display("FAIL flush rsp_valid cyc=%0d got=%0b exp=%0b", c, rsp_valid, e_vld);
         end
         if (e_vld) begin
            checks++;
            if ({rsp_instr, rsp_pc, rsp_err} !== {e_instr, e_pc, e_err}) begin
               failures++;
               $display("FAIL flush rsp got=%h/%h/%0b exp=%h/%h/%0b",
                        rsp_instr, rsp_pc, rsp_err, e_instr, e_pc, e_err);
            end
         end
         tick();
      end
   endtask

   task automatic test_rw_collision();
      for (int c = 0; c < 9; c++) begin
         idle();
         rsp_ready = 1'b1;
         if (c == 0) begin
            load_we   = 1'b1;
            load_addr = AW'(5);
            load_data = 32'hAAAA_5555;
         end
         req_valid = (c == 0) || (c == 4);
         req_pc    = 32'h14;
         #1;
         exp_calc();
         checks++;
         if (rsp_valid !== e_vld) begin
            failures++;
            $display("FAIL rw rsp_valid cyc=%0d got=%0b exp=%0b", c, rsp_valid, e_vld);
         end
         if (e_vld) begin
            checks++;
            if ({rsp_instr, rsp_pc, rsp_err} !== {e_instr, e_pc, e_err}) begin
               failures++;
               $display("FAIL rw rsp got=%h/%h/%0b exp=%h/%h/%0b",
                        rsp_instr, rsp_pc, rsp_err, e_instr, e_pc, e_err);
            end
         end
         tick();
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 412; c++) begin
         idle();
         rsp_ready = (c >= 400) || ($urandom_range(0, 3) != 0);
         if (c < 400) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_pc    = rand_pc();
            flush     = ($urandom_range(0, 19) == 0);
            boot_done = ($urandom_range(0, 29) == 0);
            load_we   = ($urandom_range(0, 9) == 0);
            load_addr = AW'($urandom_range(0, 63));
            load_data = $urandom;
         end
         #1;
         exp_calc();
         checks++;
         if (req_ready !== e_rdy) begin
            failures++;
            $display("FAIL rand req_ready cyc=%0d got=%0b exp=%0b", c, req_ready, e_rdy);
         end
         checks++;
         if (rsp_valid !== e_vld) begin
            failures++;
            $display("FAIL rand rsp_valid cyc=%0d got=%0b exp=%0b", c, rsp_valid, e_vld);
         end
         if (e_vld) begin
            checks++;
            if ({rsp_instr, rsp_pc, rsp_err} !== {e_instr, e_pc, e_err}) begin
               failures++;
               $display("FAIL rand rsp cyc=%0d got=%h/%h/%0b exp=%h/%h/%0b", c,
                        rsp_instr, rsp_pc, rsp_err, e_instr, e_pc, e_err);
            end
         end
         tick();
      end
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL rand drain left=%0d exp=0", q.size());
      end
   endtask

   task automatic test_reset_mid();
      for (int c = 0; c < 13; c++) begin
         idle();
         rsp_ready = (c >= 7);
         unique case (c)
            0: begin req_valid = 1'b1; req_pc = 32'h0; end
            1: begin req_valid = 1'b1; req_pc = 32'h4; end
            4: rst_n = 1'b0;
            6: begin boot_done = 1'b1; req_valid = 1'b1; end
            7: begin req_valid = 1'b1; req_pc = 32'h0; end
            default: ;
         endcase
         #1;
         exp_calc();
         checks++;
         if (req_ready !== e_rdy) begin
            failures++;
            $display("FAIL rstmid req_ready cyc=%0d got=%0b exp=%0b", c, req_ready, e_rdy);
         end
         checks++;
         if (rsp_valid !== e_vld) begin
            failures++;
            $display("FAIL rstmid rsp_valid cyc=%0d got=%0b exp=%0b", c, rsp_valid, e_vld);
         end
         if (e_vld) begin
            checks++;
            if ({rsp_instr, rsp_pc, rsp_err} !== {e_instr, e_pc, e_err}) begin
               failures++;
               $display("FAIL rstmid rsp got=%h/%h/%0b exp=%h/%h/%0b",
                        rsp_instr, rsp_pc, rsp_err, e_instr, e_pc, e_err);
            end
         end
         tick();
      end
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL rstmid drain left=%0d exp=0", q.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < (1 << AW); i++) mem_m[i] = '0;
      run = 1'b0;
      idle();
      rst_n = 1'b0;
      @(negedge clk);
      test_reset();
      test_load();
      test_basic();
      test_backpressure();
      test_errors();
      test_flush();
      test_rw_collision();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
